// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state type, default timing and counter width helper for key_event_decoder
package key_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } key_state_t;

    // Defaults assume a 100 MHz clock
    localparam int LONG_TIME_DEF   = 100_000_000;
    localparam int DBL_GAP_DEF     = 30_000_000;
    localparam int REPEAT_TIME_DEF = 10_000_000;

    function automatic int key_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    localparam int CNT_W = key_cnt_w(LONG_TIME_DEF, DBL_GAP_DEF, REPEAT_TIME_DEF);

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - registers the key level, gives rise/fall strobes and registered press/release pulses
module key_edge_detect
(
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic rise,
    output logic fall,
    output logic press_pulse,
    output logic release_pulse
);

    logic key_prev;

    assign rise = key_level & ~key_prev;
    assign fall = ~key_level & key_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            key_prev      <= key_level;
            press_pulse   <= rise;
            release_pulse <= fall;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies a debounced key into click/double/long/repeat pulses; KEY_REPEAT_EN enables auto-repeat
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int LONG_TIME   = LONG_TIME_DEF,
    parameter int DBL_GAP     = DBL_GAP_DEF,
    parameter int REPEAT_TIME = REPEAT_TIME_DEF
)
(
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int CW = key_cnt_w(LONG_TIME, DBL_GAP, REPEAT_TIME);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_TIME - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(DBL_GAP - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic          rise;
    logic          fall;
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic          short_nxt;
    logic          dbl_nxt;
    logic          long_nxt;
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_END = CW'(REPEAT_TIME - 1);
    logic          rep_nxt;
`endif

    key_edge_detect u_edge (
        .clk           (clk),
        .rst           (rst),
        .key_level     (key_level),
        .rise          (rise),
        .fall          (fall),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        short_nxt = 1'b0;
        dbl_nxt   = 1'b0;
        long_nxt  = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_nxt   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rise) state_nxt = ST_PRESS1;
            end
            // A fall wins over a coincident long-press expiry
            ST_PRESS1: begin
                if (fall) begin
                    state_nxt = ST_WAIT2;
                end else if (cnt == LONG_END) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                end
            end
            // Gap expiry wins over a coincident rise, which then opens a fresh first press
            ST_WAIT2: begin
                if (cnt == GAP_END) begin
                    short_nxt = 1'b1;
                    state_nxt = rise ? ST_PRESS1 : ST_IDLE;
                end else if (rise) begin
                    state_nxt = ST_PRESS2;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                    dbl_nxt   = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt == REP_END) begin
                    rep_nxt = 1'b1;
                    cnt_clr = 1'b1;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            short_click  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_nxt;
            short_click  <= short_nxt;
            double_click <= dbl_nxt;
            long_press   <= long_nxt;
            if (state_nxt != state || cnt_clr) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= rep_nxt;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
